// File: rtl/eep_arb_if.sv
// +----------------------------------------------------------------------------+
// | eep_arb_if : request/grant and EEPROM pin bundle for the EEPROM arbiter     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface eep_arb_if;
  logic        dp_req;
  logic [1:0]  dp_addr;
  logic        dp_gnt;
  logic        dp_vld;
  logic        cmd_req;
  logic        cmd_wr;
  logic [1:0]  cmd_addr;
  logic [13:0] cmd_wdata;
  logic        cmd_gnt;
  logic        cmd_done;
  logic [13:0] rd_data;
  logic [13:0] eep_rd_data;
  logic [1:0]  eep_addr;
  logic        eep_cs_n;
  logic        eep_r_w_n;
  logic        chrg_pmp_en;
  logic [13:0] wrt_data;
  logic        busy;

  modport slave (
    input  dp_req, dp_addr, cmd_req, cmd_wr, cmd_addr, cmd_wdata, eep_rd_data,
    output dp_gnt, dp_vld, cmd_gnt, cmd_done, rd_data, eep_addr, eep_cs_n,
           eep_r_w_n, chrg_pmp_en, wrt_data, busy
  );

  modport master (
    output dp_req, dp_addr, cmd_req, cmd_wr, cmd_addr, cmd_wdata, eep_rd_data,
    input  dp_gnt, dp_vld, cmd_gnt, cmd_done, rd_data, eep_addr, eep_cs_n,
           eep_r_w_n, chrg_pmp_en, wrt_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/eep_arb.sv
// +----------------------------------------------------------------------------+
// | eep_arb : datapath/command arbiter and access sequencer for the 4x14 EEPROM |
// | Option macro EEP_ARB_RR_EN selects round-robin instead of fixed priority.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module eep_arb #(
  parameter int CHRG_CYCLES = 1500000
) (
  input  wire logic clk,
  input  wire logic rst_n,
  eep_arb_if.slave  bus
);

  localparam int             CW   = $clog2(CHRG_CYCLES + 1);
  localparam logic [CW-1:0]  LOAD = CW'(CHRG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_RD_CAP   = 3'd2,
    S_WR_SETUP = 3'd3,
    S_WR_PUMP  = 3'd4,
    S_WR_DONE  = 3'd5
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          owner_cmd;
  logic          pick_cmd;
  logic          grant_dp, grant_cmd;

`ifdef EEP_ARB_RR_EN
  // last_cmd resets high so the datapath wins the first contest
  logic last_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_cmd <= 1'b1;
    else if (grant_dp || grant_cmd)
      last_cmd <= grant_cmd;
  end

  assign pick_cmd = bus.cmd_req && (!bus.dp_req || !last_cmd);
`else
  assign pick_cmd = bus.cmd_req && !bus.dp_req;
`endif

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    grant_dp  = 1'b0;
    grant_cmd = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_cmd) begin
          grant_cmd = 1'b1;
          state_d   = bus.cmd_wr ? S_WR_SETUP : S_RD;
        end else if (bus.dp_req) begin
          grant_dp = 1'b1;
          state_d  = S_RD;
        end
      end
      S_RD:       state_d = S_RD_CAP;
      S_RD_CAP:   state_d = S_IDLE;
      S_WR_SETUP: begin
        state_d = S_WR_PUMP;
        cnt_d   = LOAD;
      end
      S_WR_PUMP: begin
        if (cnt == '0)
          state_d = S_WR_DONE;
        else
          cnt_d = cnt - CW'(1);
      end
      S_WR_DONE:  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Pin outputs are decoded from the next state so they are registered yet
  // line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      owner_cmd       <= 1'b0;
      bus.dp_gnt      <= 1'b0;
      bus.dp_vld      <= 1'b0;
      bus.cmd_gnt     <= 1'b0;
      bus.cmd_done    <= 1'b0;
      bus.rd_data     <= '0;
      bus.eep_addr    <= '0;
      bus.eep_cs_n    <= 1'b1;
      bus.eep_r_w_n   <= 1'b1;
      bus.chrg_pmp_en <= 1'b0;
      bus.wrt_data    <= '0;
      bus.busy        <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      bus.dp_gnt   <= grant_dp;
      bus.cmd_gnt  <= grant_cmd;
      if (grant_dp || grant_cmd) begin
        owner_cmd    <= grant_cmd;
        bus.eep_addr <= grant_cmd ? bus.cmd_addr : bus.dp_addr;
      end
      if (grant_cmd && bus.cmd_wr)
        bus.wrt_data <= bus.cmd_wdata;
      if (state == S_RD_CAP)
        bus.rd_data <= bus.eep_rd_data;
      bus.dp_vld      <= (state == S_RD_CAP) && !owner_cmd;
      bus.cmd_done    <= ((state == S_RD_CAP) && owner_cmd) || (state_d == S_WR_DONE);
      bus.eep_cs_n    <= (state_d == S_IDLE) || (state_d == S_WR_DONE);
      bus.eep_r_w_n   <= !((state_d == S_WR_SETUP) || (state_d == S_WR_PUMP));
      bus.chrg_pmp_en <= (state_d == S_WR_PUMP);
      bus.busy        <= (state_d != S_IDLE);
    end
  end

endmodule

`default_nettype wire

// File: doc/eep_arb.md
# eep_arb

Arbiter and access sequencer for the shared 4-entry × 14-bit EEPROM in `cbc_dig`. It serves two requesters:

- **Datapath:** read-only, fetches the stored coefficients.
- **Command processor:** read and write, serving UART cfg commands.

It drives the EEPROM pins directly (`eep_addr`, `eep_cs_n`, `eep_r_w_n`, `chrg_pmp_en`, write data onto `dst`) and times the charge-pump interval for writes.

## Interface
Parameters:
- `CHRG_CYCLES`, default 1500000: number of cycles `chrg_pmp_en` is held high per write (3 ms at 500 MHz). Must be ≥ 1.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `dp_req`  in  1  datapath read request (level)
- `dp_addr`  in  2  datapath read address
- `dp_gnt`  out  1  one-cycle pulse: datapath request accepted
- `dp_vld`  out  1  one-cycle pulse: `rd_data` holds datapath result
- `cmd_req`  in  1  command request (level)
- `cmd_wr`  in  1  1 = write, 0 = read
- `cmd_addr`  in  2  command address
- `cmd_wdata`  in  14  command write data
- `cmd_gnt`  out  1  one-cycle pulse: command request accepted
- `cmd_done`  out  1  one-cycle pulse: command read or write complete
- `rd_data`  out  14  last captured EEPROM read word
- `eep_rd_data`  in  14  EEPROM read data
- `eep_addr`  out  2  EEPROM address
- `eep_cs_n`  out  1  EEPROM chip select, active-low
- `eep_r_w_n`  out  1  1 = read, 0 = write
- `chrg_pmp_en`  out  1  charge pump enable
- `wrt_data`  out  14  EEPROM write data (to `dst`)
- `busy`  out  1  high in any state other than IDLE

## Operation
- **Request protocol.** Each requester holds `req` high until it sees its `gnt` pulse. Address and write data are sampled at the accepting edge. A request still high after `gnt` counts as a new request.
- **States:** IDLE, RD, RD_CAP, WR_SETUP, WR_PUMP, WR_DONE.
- **IDLE.** Pins are inactive: `eep_cs_n` = 1, `eep_r_w_n` = 1, `chrg_pmp_en` = 0. The arbiter picks a winner:
  - datapath wins → RD;
  - command with `cmd_wr` = 0 → RD;
  - command with `cmd_wr` = 1 → WR_SETUP.
- **RD.** `eep_cs_n` = 0, `eep_r_w_n` = 1, `eep_addr` = latched address. Next state is RD_CAP.
- **RD_CAP.** Pins are held as in RD. At the end of the cycle `eep_rd_data` is registered into `rd_data`, and the state returns to IDLE. In the following cycle `dp_vld` or `cmd_done` pulses, according to the owner.
- **WR_SETUP.** `eep_cs_n` = 0, `eep_r_w_n` = 0, `eep_addr` and `wrt_data` latched. The counter loads `CHRG_CYCLES-1`. Next state is WR_PUMP.
- **WR_PUMP.** `chrg_pmp_en` = 1 with `cs_n`, `r_w_n`, `addr` and `wrt_data` held stable. The counter decrements each cycle; at 0 the state moves to WR_DONE. The counter width is `$clog2(CHRG_CYCLES+1)`.
- **WR_DONE.** `chrg_pmp_en` = 0, `eep_cs_n` = 1, `eep_r_w_n` = 1. `cmd_done` pulses. Next state is IDLE.
- **Holding outputs.** `wrt_data` and `rd_data` hold their values until the next write or read respectively.
- **Arbitration while busy.** Requests arriving outside IDLE are not granted; they wait for IDLE.

## Timing
- All outputs are registered. Reset values are all 0, except `eep_cs_n` = 1 and `eep_r_w_n` = 1.
- `gnt` pulses in the first cycle of RD or WR_SETUP.
- Read: with the request sampled at edge k, `dp_vld`/`cmd_done` is high in the cycle after edge k+2. The next grant is possible at edge k+3.
- Write: `chrg_pmp_en` is high for exactly `CHRG_CYCLES` cycles, starting one cycle after `cmd_gnt`. `cmd_done` pulses in the cycle immediately after `chrg_pmp_en` falls.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). The write is aborted and no done pulse is issued. The arbitration pointer resets to favour the datapath.

## Configuration
- `EEP_ARB_RR_EN` defined: round-robin. On simultaneous requests, the requester not granted last wins. After reset the datapath is favoured.
- `EEP_ARB_RR_EN` undefined: fixed priority, datapath always wins. Command starvation is permitted; the datapath issues at most one read per accel sample.

## Test plan
- **Datapath read.** EEPROM addr 2 = 0x1234, `dp_req` with `dp_addr` = 2 sampled at edge k → `dp_gnt` in the cycle after k; `dp_vld` after k+2 with `rd_data` = 0x1234; `cmd_done` stays 0.
- **Command write, then read.** `CHRG_CYCLES` = 8, command write addr 1 data 0x2ABC → `chrg_pmp_en` high exactly 8 cycles; `eep_addr` = 1 and `wrt_data` = 0x2ABC stable throughout; then one `cmd_done`. A following command read of addr 1 returns 0x2ABC.
- **Simultaneous held requests.** `dp_req` and `cmd_req` (read) held for 4 grants → without the macro: dp, dp, dp, dp; with `EEP_ARB_RR_EN`: dp, cmd, dp, cmd.
- **Request during write.** `dp_req` raised during WR_PUMP → no `dp_gnt` until IDLE; `dp_gnt` arrives in the second cycle after the `cmd_done` cycle.
- **Reset mid-pump.** `rst_n` low in the 3rd WR_PUMP cycle → `chrg_pmp_en` = 0 and `eep_cs_n` = 1 within the same cycle; no `cmd_done`. After release, a fresh datapath read completes normally.
